// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared constants and FSM encodings for the bit-serial subtractor
package sub_pkg;
   localparam int N_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/fs.sv
// rtl/fs.sv - one-bit full subtractor cell
module fs (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial N-bit subtractor, LSB first, one bit per clock
module serial_sub
   import sub_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] diff,
   output logic         bout
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t         state, state_nx;
   logic [CW-1:0]  cnt;
   logic           br;
   logic [N-1:0]   a_sh, b_sh, diff_sh;
   logic           bout_r;
   logic           d_bit, br_nx;
   logic           load;

   fs u_fs (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (br),
      .d    (d_bit),
      .bout (br_nx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      load     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            // A start here is a back-to-back request: the done pulse still goes out.
            if (start) begin
               load     = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         diff_sh <= '0;
         cnt     <= '0;
         br      <= 1'b0;
         bout_r  <= 1'b0;
      end else if (load) begin
         a_sh <= a;
         b_sh <= b;
         br   <= bin;
         cnt  <= '0;
      end else if (state == RUN) begin
         // Result bits enter at the MSB so bit 0 settles at diff[0] after N shifts.
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         diff_sh <= {d_bit, diff_sh[N-1:1]};
         br      <= br_nx;
         cnt     <= cnt + 1'b1;
         if (cnt == LAST) bout_r <= br_nx;
      end
   end

   assign diff = diff_sh;
   assign bout = bout_r;
endmodule
